// File: rtl/bcd_timer_pkg.sv
`default_nettype none
// ============================================================================
// bcd_timer_pkg : state encoding, BCD limits and nibble check for the timer
// Revision      : 1.0
// ============================================================================
package bcd_timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READY = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [3:0] BCD_MAX = 4'd9;
   localparam logic [3:0] BCD_MIN = 4'd0;

   function automatic logic is_bcd(input logic [3:0] nib);
      return (nib <= BCD_MAX);
   endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_cell.sv
`default_nettype none
// ============================================================================
// bcd_digit_cell : one decimal digit, up/down with wrap; ld wins over ce
// Revision       : 1.0
// ============================================================================
module bcd_digit_cell
   import bcd_timer_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ce,
   input  logic       up,
   input  logic       ld,
   input  logic [3:0] d,
   output logic [3:0] q,
   output logic       at_ripple
);

   logic [3:0] r_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_q <= BCD_MIN;
      end else if (ld) begin
         r_q <= d;
      end else if (ce) begin
         if (up) begin
            r_q <= (r_q == BCD_MAX) ? BCD_MIN : r_q + 4'd1;
         end else begin
            r_q <= (r_q == BCD_MIN) ? BCD_MAX : r_q - 4'd1;
         end
      end
   end

   assign q         = r_q;
   assign at_ripple = up ? (r_q == BCD_MAX) : (r_q == BCD_MIN);

endmodule
`default_nettype wire

// File: rtl/bcd_timer_ctrl.sv
`default_nettype none
// ============================================================================
// bcd_timer_ctrl : run/pause/done sequencing for a cascaded BCD digit chain
// Revision       : 1.0
// ============================================================================
module bcd_timer_ctrl
   import bcd_timer_pkg::*;
#(
   parameter int NDIG = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              tick,
   input  logic              dir,
   input  logic              load,
   input  logic [4*NDIG-1:0] load_val,
   input  logic              start,
   input  logic              stop,
   input  logic              clear,
   output logic [4*NDIG-1:0] count,
   output logic [1:0]        state,
   output logic              busy,
   output logic              done,
   output logic              load_err
);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [4*NDIG-1:0] r_target;
   logic [4*NDIG-1:0] w_target_nxt;
   logic              r_dir;
   logic              w_dir_nxt;
   logic              r_done;
   logic              w_done_nxt;
   logic              r_load_err;
   logic              w_err_nxt;

   logic              w_ld;
   logic [4*NDIG-1:0] w_ld_val;
   logic              w_step;
   logic [NDIG-1:0]   w_carry;
   logic [NDIG-1:0]   w_ripple;
   logic [NDIG-1:0]   w_nib_ok;
   logic [4*NDIG-1:0] w_count;
   logic [4*NDIG-1:0] w_step_val;
   logic [4*NDIG-1:0] w_term;

   // A tick only steps when no higher-priority request is present.
   assign w_step = tick & ~clear & ~load & ~stop & ~start & (r_state == ST_RUN);
   assign w_term = r_dir ? r_target : '0;

   generate
      for (genvar i = 0; i < NDIG; i++) begin : g_digit
         if (i == 0) begin : g_lsb
            assign w_carry[i] = 1'b1;
         end else begin : g_upper
            assign w_carry[i] = w_carry[i-1] & w_ripple[i-1];
         end

         assign w_nib_ok[i] = is_bcd(load_val[4*i +: 4]);

         // Value after a step, used for the terminal compare on the same edge.
         always_comb begin
            w_step_val[4*i +: 4] = w_count[4*i +: 4];
            if (w_carry[i]) begin
               if (r_dir) begin
                  w_step_val[4*i +: 4] = (w_count[4*i +: 4] == BCD_MAX) ? BCD_MIN
                                       : w_count[4*i +: 4] + 4'd1;
               end else begin
                  w_step_val[4*i +: 4] = (w_count[4*i +: 4] == BCD_MIN) ? BCD_MAX
                                       : w_count[4*i +: 4] - 4'd1;
               end
            end
         end

         bcd_digit_cell u_cell (
            .clk       (clk),
            .rst_n     (rst_n),
            .ce        (w_step & w_carry[i]),
            .up        (r_dir),
            .ld        (w_ld),
            .d         (w_ld_val[4*i +: 4]),
            .q         (w_count[4*i +: 4]),
            .at_ripple (w_ripple[i])
         );
      end
   endgenerate

   always_comb begin
      w_state_nxt  = r_state;
      w_target_nxt = r_target;
      w_dir_nxt    = r_dir;
      w_done_nxt   = 1'b0;
      w_err_nxt    = 1'b0;
      w_ld         = 1'b0;
      w_ld_val     = '0;

      if (clear) begin
         w_state_nxt  = ST_IDLE;
         w_target_nxt = '0;
         w_ld         = 1'b1;
      end else if (load) begin
         if (r_state != ST_RUN) begin
            if (!(&w_nib_ok)) begin
               w_err_nxt = 1'b1;
            end else begin
               w_state_nxt  = ST_READY;
               w_target_nxt = load_val;
               w_dir_nxt    = dir;
               w_ld         = 1'b1;
               w_ld_val     = dir ? '0 : load_val;
            end
         end
      end else if (stop) begin
         if (r_state == ST_RUN) begin
            w_state_nxt = ST_READY;
         end
      end else if (start) begin
         if (r_state == ST_READY) begin
            if (w_count == w_term) begin
               w_state_nxt = ST_DONE;
               w_done_nxt  = 1'b1;
            end else begin
               w_state_nxt = ST_RUN;
            end
         end
      end else if (w_step) begin
         if (w_step_val == w_term) begin
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_target   <= '0;
         r_dir      <= 1'b0;
         r_done     <= 1'b0;
         r_load_err <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_target   <= w_target_nxt;
         r_dir      <= w_dir_nxt;
         r_done     <= w_done_nxt;
         r_load_err <= w_err_nxt;
      end
   end

   assign count    = w_count;
   assign state    = r_state;
   assign busy     = (r_state == ST_RUN);
   assign done     = r_done;
   assign load_err = r_load_err;

endmodule
`default_nettype wire

// File: tb/tb_bcd_timer_ctrl.sv
`default_nettype none
// ============================================================================
// tb_bcd_timer_ctrl : directed and random stimulus against an integer model
// Revision          : 1.0
// ============================================================================
module tb_bcd_timer_ctrl;

   localparam int NDIG = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              tick, dir, load, start, stop, clear;
   logic [4*NDIG-1:0] load_val;
   logic [4*NDIG-1:0] count;
   logic [1:0]        state;
   logic              busy, done, load_err;

   int n_vec = 0;
   int n_err = 0;

   // Model: timer value and target held as plain integers.
   int m_val   = 0;
   int m_tgt   = 0;
   bit m_dir   = 0;
   int m_state = 0;
   bit m_done  = 0;
   bit m_lerr  = 0;

   always #5 clk = ~clk;

   bcd_timer_ctrl #(.NDIG(NDIG)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick     (tick),
      .dir      (dir),
      .load     (load),
      .load_val (load_val),
      .start    (start),
      .stop     (stop),
      .clear    (clear),
      .count    (count),
      .state    (state),
      .busy     (busy),
      .done     (done),
      .load_err (load_err)
   );

   function automatic int bcd2int(input logic [4*NDIG-1:0] b);
      int r = 0;
      for (int i = NDIG-1; i >= 0; i--) r = r*10 + int'(b[4*i +: 4]);
      return r;
   endfunction

   function automatic logic [4*NDIG-1:0] int2bcd(input int v);
      logic [4*NDIG-1:0] r;
      int t = v;
      for (int i = 0; i < NDIG; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic bit bcd_ok(input logic [4*NDIG-1:0] b);
      for (int i = 0; i < NDIG; i++) if (b[4*i +: 4] > 4'd9) return 0;
      return 1;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // One clock: evaluate the model on the current inputs, take the edge, compare.
   task automatic cycle();
      int  nval   = m_val;
      int  ntgt   = m_tgt;
      bit  ndir   = m_dir;
      int  nstate = m_state;
      bit  ndone  = 0;
      bit  nlerr  = 0;
      int  term   = m_dir ? m_tgt : 0;
      if (!rst_n) begin
         nval = 0; ntgt = 0; ndir = 0; nstate = 0;
      end else if (clear) begin
         nval = 0; ntgt = 0; nstate = 0;
      end else if (load) begin
         if (m_state != 2) begin
            if (!bcd_ok(load_val)) nlerr = 1;
            else begin
               ntgt   = bcd2int(load_val);
               ndir   = dir;
               nval   = dir ? 0 : ntgt;
               nstate = 1;
            end
         end
      end else if (stop) begin
         if (m_state == 2) nstate = 1;
      end else if (start) begin
         if (m_state == 1) begin
            if (m_val == term) begin nstate = 3; ndone = 1; end
            else nstate = 2;
         end
      end else if (tick) begin
         if (m_state == 2) begin
            nval = m_dir ? m_val + 1 : m_val - 1;
            if (nval == term) begin nstate = 3; ndone = 1; end
         end
      end
      @(posedge clk);
      #1;
      m_val = nval; m_tgt = ntgt; m_dir = ndir; m_state = nstate;
      m_done = ndone; m_lerr = nlerr;
      chk("count",    32'(count),    32'(int2bcd(m_val)));
      chk("state",    32'(state),    32'(m_state));
      chk("busy",     32'(busy),     32'(m_state == 2));
      chk("done",     32'(done),     32'(m_done));
      chk("load_err", 32'(load_err), 32'(m_lerr));
   endtask

   task automatic idle_inputs();
      tick = 0; dir = 0; load = 0; start = 0; stop = 0; clear = 0; load_val = '0;
   endtask

   task automatic do_load(input logic [4*NDIG-1:0] v, input logic d);
      load = 1; load_val = v; dir = d;
      cycle();
      idle_inputs();
   endtask

   task automatic do_start();
      start = 1; cycle(); start = 0;
   endtask

   task automatic do_tick();
      tick = 1; cycle(); tick = 0;
   endtask

   initial begin
      rst_n = 0;
      idle_inputs();
      cycle();
      cycle();
      chk("rst_count", 32'(count), 32'h0);
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_busy",  32'(busy),  32'd0);
      rst_n = 1;

      // Down count to zero.
      do_load(16'h0003, 1'b0);
      do_start();
      chk("dn_run", 32'(state), 32'd2);
      do_tick(); chk("dn_2", 32'(count), 32'h0002);
      do_tick(); chk("dn_1", 32'(count), 32'h0001);
      do_tick();
      chk("dn_0", 32'(count), 32'h0000);
      chk("dn_done", 32'(done), 32'd1);
      chk("dn_st", 32'(state), 32'd3);
      do_tick();
      chk("dn_hold", 32'(count), 32'h0000);
      chk("dn_pulse", 32'(done), 32'd0);

      // Up count through a carry.
      do_load(16'h0012, 1'b1);
      chk("up_ld", 32'(count), 32'h0000);
      do_start();
      for (int i = 0; i < 10; i++) do_tick();
      chk("up_10", 32'(count), 32'h0010);
      do_tick(); do_tick();
      chk("up_12", 32'(count), 32'h0012);
      chk("up_done", 32'(done), 32'd1);
      chk("up_busy", 32'(busy), 32'd0);

      // Borrow across three digits.
      do_load(16'h1000, 1'b0);
      do_start();
      do_tick();
      chk("brw_cnt", 32'(count), 32'h0999);
      chk("brw_st", 32'(state), 32'd2);

      // Rejected load leaves everything untouched.
      clear = 1; cycle(); clear = 0;
      do_load(16'h0042, 1'b0);
      do_load(16'h00A5, 1'b0);
      chk("ierr", 32'(load_err), 32'd1);
      chk("ierr_cnt", 32'(count), 32'h0042);
      chk("ierr_st", 32'(state), 32'd1);
      cycle();
      chk("ierr_pulse", 32'(load_err), 32'd0);

      // Pause with a simultaneous tick, then resume.
      do_load(16'h0009, 1'b0);
      do_start();
      do_tick(); do_tick();
      stop = 1; tick = 1; cycle(); stop = 0; tick = 0;
      chk("pz_st", 32'(state), 32'd1);
      chk("pz_cnt", 32'(count), 32'h0007);
      do_start();
      do_tick();
      chk("rs_cnt", 32'(count), 32'h0006);

      // Clear beats load in RUN.
      clear = 1; load = 1; load_val = 16'h0055;
      cycle();
      idle_inputs();
      chk("clr_st", 32'(state), 32'd0);
      chk("clr_cnt", 32'(count), 32'h0000);

      // Reset mid-run, then start is ignored until the next load.
      do_load(16'h0050, 1'b0);
      do_start();
      do_tick();
      rst_n = 0; cycle(); rst_n = 1;
      chk("mrst_cnt", 32'(count), 32'h0000);
      chk("mrst_st", 32'(state), 32'd0);
      do_start();
      chk("mrst_start", 32'(state), 32'd0);

      // Random phase.
      for (int n = 0; n < 4000; n++) begin
         int r;
         rst_n = ($urandom_range(0, 299) != 0);
         clear = ($urandom_range(0, 99) < 2);
         load  = ($urandom_range(0, 99) < 8);
         stop  = ($urandom_range(0, 99) < 5);
         start = ($urandom_range(0, 99) < 15);
         tick  = ($urandom_range(0, 99) < 60);
         dir   = 1'($urandom_range(0, 1));
         r = $urandom_range(0, 99);
         if (r < 70)      load_val = int2bcd($urandom_range(0, 40));
         else if (r < 85) load_val = int2bcd($urandom_range(0, 9999));
         else             load_val = 16'($urandom);
         cycle();
      end
      idle_inputs();
      rst_n = 1;
      cycle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
